axi_stream_ram_reader: RTL

Transmit-side counterpart of the sample-RAM stream writer. It reads a contiguous block of words from the 64-entry, 32-bit sample RAM (synchronous read, 1-cycle latency) and presents them as an AXI-Stream master (T_DATA/T_VALID/T_READY/T_LAST) toward the downstream consumer. A 2-entry skid FIFO absorbs the RAM read latency so that sustained throughput is one word per clock while T_READY is held high.

---
 rtl/axi_stream_ram_reader.sv | 138 +++++++++++++
 1 files changed

// File: rtl/axi_stream_ram_reader.sv
// Streams a contiguous block of sample-RAM words out as an AXI-Stream master.
// A 2-entry skid FIFO hides the 1-cycle RAM read latency for full throughput.
module axi_stream_ram_reader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start,
    input  logic [ADDR_WIDTH-1:0] Start_Address,
    input  logic [ADDR_WIDTH:0]   Length,
    input  logic [DATA_WIDTH-1:0] RAM_Data,
    output logic                  Read_Enable,
    output logic [ADDR_WIDTH-1:0] Read_Address,
    input  logic                  T_READY,
    output logic [DATA_WIDTH-1:0] T_DATA,
    output logic                  T_VALID,
    output logic                  T_LAST,
    output logic                  Busy,
    output logic                  Done
);

    typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

    localparam logic [ADDR_WIDTH:0]   MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]   rd_rem_q, rd_rem_d;
    logic [ADDR_WIDTH:0]   tx_rem_q, tx_rem_d;
    logic                  in_flight_q, in_flight_d;
    logic [DATA_WIDTH-1:0] mem_q [2];
    logic                  head_q, tail_q;
    logic [1:0]            occ_q;

    logic                  pop;
    logic                  push;
    logic                  rd_en;
    logic                  accept;
    logic [ADDR_WIDTH:0]   len_clamped;

    assign pop         = (occ_q != 2'd0) && T_READY;
    assign push        = in_flight_q;
    assign accept      = (state_q == IDLE) && Start;
    assign len_clamped = (Length > MAX_LEN) ? MAX_LEN : Length;
    // Issue a read only if the word can be guaranteed a FIFO slot when it lands.
    assign rd_en = (state_q == STREAM) && (rd_rem_q != '0) &&
                   (({1'b0, occ_q} + {2'b00, in_flight_q}) < (3'd2 + {2'b00, pop}));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (Start) state_d = (Length == '0) ? FINISH : STREAM;
            STREAM:  if (pop && (tx_rem_q == CNT_ONE)) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Busy         = (state_q == STREAM);
        Done         = (state_q == FINISH);
        Read_Enable  = rd_en;
        Read_Address = ptr_q;
        T_VALID      = (occ_q != 2'd0);
        T_LAST       = (occ_q != 2'd0) && (tx_rem_q == CNT_ONE);
        T_DATA       = mem_q[head_q];
    end

    always_comb begin
        ptr_d       = ptr_q;
        rd_rem_d    = rd_rem_q;
        tx_rem_d    = tx_rem_q;
        in_flight_d = rd_en;
        if (accept) begin
            ptr_d    = Start_Address;
            rd_rem_d = len_clamped;
            tx_rem_d = len_clamped;
        end else begin
            if (rd_en) begin
                ptr_d    = ptr_q + PTR_ONE;
                rd_rem_d = rd_rem_q - CNT_ONE;
            end
            if (pop) begin
                tx_rem_d = tx_rem_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q       <= '0;
            rd_rem_q    <= '0;
            tx_rem_q    <= '0;
            in_flight_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            rd_rem_q    <= rd_rem_d;
            tx_rem_q    <= tx_rem_d;
            in_flight_q <= in_flight_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            head_q <= 1'b0;
            tail_q <= 1'b0;
            occ_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[tail_q] <= RAM_Data;
                tail_q        <= ~tail_q;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
            unique case ({push, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule
